mul8_sequencer: RTL and testbench

Multi-cycle 8x8 multiplier controller for the calculator datapath. Time-shares the existing single 4x4 combinational `multiplier` instance across four partial products, and accumulates them into a 16-bit result. It sits between the calculator operation decoder, which drives `start` and the operands, and the result/display register, which consumes `product` on `done`. The controller uses a start/busy/done handshake, so the decoder needs no knowledge of the multiplier's internals.

---
 rtl/mul8_sequencer_if.sv | 15 +
 rtl/mul8_sequencer.sv | 147 ++++++++++++++
 tb/tb_mul8_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mul8_sequencer_if.sv
// Start/busy/done handshake bundle between the operation decoder (master)
// and the 8x8 multiply sequencer (slave).
interface mul8_sequencer_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  modport master (output start, output a, output b,
                  input  product, input busy, input done);
  modport slave  (input  start, input a, input b,
                  output product, output busy, output done);
endinterface

// File: rtl/mul8_sequencer.sv
// Multi-cycle 8x8->16 multiplier built from one shared 4x4 multiplier.
// Optional two's-complement operands when MUL_SEQ_SIGNED_EN is defined.
module multiplier (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  assign p = 8'(x) * 8'(y);
endmodule

module mul8_sequencer (
  input  logic              clk,
  input  logic              rst,
  mul8_sequencer_if.slave   bus
);
  localparam int unsigned OP_W  = 8;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned PP_W  = 8;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned K_W   = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [K_W-1:0]     k, k_n;
  logic [OP_W-1:0]    op_a, op_a_n;
  logic [OP_W-1:0]    op_b, op_b_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [ACC_W-1:0]   product, product_n;
  logic               busy, busy_n;
  logic               done, done_n;
`ifdef MUL_SEQ_SIGNED_EN
  logic               sign, sign_n;
`endif

  logic [NIB_W-1:0]   nib_a, nib_b;
  logic [PP_W-1:0]    pp;
  logic [ACC_W-1:0]   pp_shifted;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   result;

  // k[0] picks the high nibble of a, k[1] the high nibble of b
  assign nib_a = k[0] ? op_a[7:4] : op_a[3:0];
  assign nib_b = k[1] ? op_b[7:4] : op_b[3:0];

  multiplier u_mult (
    .x (nib_a),
    .y (nib_b),
    .p (pp)
  );

  always_comb begin
    pp_shifted = ACC_W'(pp);
    case (k)
      2'd0:    pp_shifted = ACC_W'(pp);
      2'd3:    pp_shifted = ACC_W'(pp) << 8;
      default: pp_shifted = ACC_W'(pp) << 4;
    endcase
  end

  assign sum = acc + pp_shifted;

`ifdef MUL_SEQ_SIGNED_EN
  assign result = sign ? ACC_W'(-sum) : sum;
`else
  assign result = sum;
`endif

  // Next-state and datapath update
  always_comb begin
    state_n   = state;
    k_n       = k;
    op_a_n    = op_a;
    op_b_n    = op_b;
    acc_n     = acc;
    product_n = product;
`ifdef MUL_SEQ_SIGNED_EN
    sign_n    = sign;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
          k_n     = '0;
          acc_n   = '0;
`ifdef MUL_SEQ_SIGNED_EN
          // -128 negates to itself, which is the correct 8-bit magnitude 0x80
          op_a_n  = bus.a[7] ? OP_W'(-bus.a) : bus.a;
          op_b_n  = bus.b[7] ? OP_W'(-bus.b) : bus.b;
          sign_n  = bus.a[7] ^ bus.b[7];
`else
          op_a_n  = bus.a;
          op_b_n  = bus.b;
`endif
        end
      end
      RUN: begin
        acc_n = sum;
        k_n   = k + K_W'(1);
        if (k == K_W'(3)) begin
          state_n   = DONE;
          product_n = result;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
      sign    <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      k       <= k_n;
      op_a    <= op_a_n;
      op_b    <= op_b_n;
      acc     <= acc_n;
      product <= product_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef MUL_SEQ_SIGNED_EN
      sign    <= sign_n;
`endif
    end
  end

  assign bus.product = product;
  assign bus.busy    = busy;
  assign bus.done    = done;
endmodule

// File: tb/tb_mul8_sequencer.sv
// Directed bench for mul8_sequencer with a cycle-level behavioural model
// and hand-computed literal expectations.
module tb_mul8_sequencer;
  logic clk = 1'b0;
  logic rst;
  mul8_sequencer_if bus ();

  mul8_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int ix, iy;
`ifdef MUL_SEQ_SIGNED_EN
    ix = int'($signed(x));
    iy = int'($signed(y));
`else
    ix = int'(x);
    iy = int'(y);
`endif
    return 16'(ix * iy);
  endfunction

  // Model: m_cnt counts cycles since acceptance (0 = idle, 5 = done cycle)
  int          m_cnt  = 0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_res  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  = 0;
      m_prod = '0;
    end else if (m_cnt == 0) begin
      if (bus.start) begin
        m_cnt = 1;
        m_res = ref_mul(bus.a, bus.b);
      end
    end else if (m_cnt < 5) begin
      m_cnt++;
      if (m_cnt == 5) m_prod = m_res;
    end else begin
      m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_busy",    16'(bus.busy), 16'(m_cnt != 0));
      check("model_done",    16'(bus.done), 16'(m_cnt == 5));
      check("model_product", bus.product,   m_prod);
    end
  end

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [15:0] exp, input bit scramble);
    bit got;
    bus.a = ia;
    bus.b = ib;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (scramble) begin
      bus.a = 8'hFF;
      bus.b = 8'h00;
    end
    check("busy_after_accept", 16'(bus.busy), 16'd1);
    got = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        got = 1'b1;
        check("done_latency", 16'(i), 16'd4);
        check("op_product", bus.product, exp);
        break;
      end
    end
    if (!got) check("done_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
    check("idle_after_done", 16'(bus.busy), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    check("rst_product", bus.product,   16'h0000);
    check("rst_busy",    16'(bus.busy), 16'd0);
    check("rst_done",    16'(bus.done), 16'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("no_accept_in_reset", 16'(bus.busy), 16'd0);

`ifdef MUL_SEQ_SIGNED_EN
    run_op(8'hFF, 8'hFF, 16'h0001, 1'b0);
`else
    run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0);
`endif
    run_op(8'h12, 8'h34, 16'h03A8, 1'b1);

    // start held high: one operation per busy window, no queued extras
    bus.a = 8'h0F;
    bus.b = 8'h10;
    bus.start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        check("held_product", bus.product, 16'h00F0);
      end
    end
    bus.start = 1'b0;
    check("held_done_count", 16'(ndone), 16'd4);

    // abort on the second RUN cycle
    bus.a = 8'h80;
    bus.b = 8'h02;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy",    16'(bus.busy), 16'd0);
    check("abort_product", bus.product,   16'h0000);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("abort_no_done", 16'(ndone), 16'd0);

`ifdef MUL_SEQ_SIGNED_EN
    run_op(8'hFE, 8'h03, 16'hFFFA, 1'b0);
    run_op(8'h80, 8'h80, 16'h4000, 1'b0);
    run_op(8'h80, 8'h01, 16'hFF80, 1'b0);
`else
    run_op(8'hFE, 8'h03, 16'h02FA, 1'b0);
    run_op(8'h80, 8'h80, 16'h4000, 1'b0);
    run_op(8'h80, 8'h01, 16'h0080, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
